// File: rtl/amiq_stim_player.sv
// Replays buffered (value, delay) pairs onto one mux input pin with cycle-exact hold times.
// Each entry is visible on drv_out for delay+1 cycles; consecutive entries follow with no gap.
module amiq_stim_player #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned DELAY_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic                       wr_value,
    input  logic [DELAY_W-1:0]         wr_delay,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       drv_out,
    output logic                       drv_strobe,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DELAY_W:0]     mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        count_q, count_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic                 drv_q, drv_d;
    logic                 strobe_q, strobe_d;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DELAY_W:0]     head;

    // Full/empty come from the registered count, so a pop cannot make room for a same-cycle write.
    assign full  = (count_q == LW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    assign wr_ready   = !full;
    assign level      = count_q;
    assign busy       = (state_q == PLAY) || (state_q == FIN);
    assign done       = (state_q == FIN);
    assign drv_out    = drv_q;
    assign drv_strobe = strobe_q;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        cnt_d    = cnt_q;
        drv_d    = drv_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = PLAY;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            drv_d    = head[DELAY_W];
            cnt_d    = head[DELAY_W-1:0];
            strobe_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            drv_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            strobe_q <= strobe_d;
        end
    end

    // Storage needs no reset: the flushed pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_value, wr_delay};
        end
    end

endmodule
